// File: rtl/dma_arbiter_if.sv
// Bundle of device-side and controller-side signals around the DMA arbiter.
interface dma_arbiter_if #(
  parameter int unsigned N_DEV    = 4,
  parameter int unsigned ADD_LEN  = 16,
  parameter int unsigned DATA_LEN = 16
);
  // Device side
  logic [N_DEV-1:0]               dev_rqst;
  logic [N_DEV-1:0]               dev_enable;
  logic [N_DEV-1:0]               dev_rd_wr;
  logic [N_DEV*ADD_LEN-1:0]       dev_num_words;
  logic [N_DEV*(ADD_LEN+1)-1:0]   dev_start_addr;
  logic [N_DEV-1:0]               dev_ack_in;
  logic [N_DEV*DATA_LEN-1:0]      dev_data_in;
  logic [N_DEV-1:0]               dev_grant;
  logic [N_DEV-1:0]               dev_dma_ack;
  logic [N_DEV-1:0]               dev_end;
  logic [DATA_LEN-1:0]            dev_data_out;
  // Controller side
  logic                           ctrl_rqst;
  logic                           ctrl_rd_wr;
  logic [ADD_LEN-1:0]             ctrl_num_words;
  logic [ADD_LEN:0]               ctrl_start_addr;
  logic                           ctrl_dev_ack;
  logic [DATA_LEN-1:0]            ctrl_dev_in;
  logic                           ctrl_dma_ack;
  logic                           ctrl_end_flag;
  logic [DATA_LEN-1:0]            ctrl_dev_out;
  // Status
  logic                           busy;
  logic [2:0]                     cur_dev;

  // Arbiter view
  modport slave (
    input  dev_rqst, dev_enable, dev_rd_wr, dev_num_words, dev_start_addr,
           dev_ack_in, dev_data_in, ctrl_dma_ack, ctrl_end_flag, ctrl_dev_out,
    output dev_grant, dev_dma_ack, dev_end, dev_data_out, ctrl_rqst, ctrl_rd_wr,
           ctrl_num_words, ctrl_start_addr, ctrl_dev_ack, ctrl_dev_in, busy, cur_dev
  );

  // Environment view (devices plus controller)
  modport master (
    output dev_rqst, dev_enable, dev_rd_wr, dev_num_words, dev_start_addr,
           dev_ack_in, dev_data_in, ctrl_dma_ack, ctrl_end_flag, ctrl_dev_out,
    input  dev_grant, dev_dma_ack, dev_end, dev_data_out, ctrl_rqst, ctrl_rd_wr,
           ctrl_num_words, ctrl_start_addr, ctrl_dev_ack, ctrl_dev_in, busy, cur_dev
  );
endinterface

// File: rtl/dma_arbiter.sv
// Round-robin arbiter multiplexing N_DEV DMA requesters onto one DMA controller.
module dma_arbiter #(
  parameter int unsigned N_DEV    = 4,
  parameter int unsigned ADD_LEN  = 16,
  parameter int unsigned DATA_LEN = 16
) (
  input logic           clk,
  input logic           reset,
  dma_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StBusy, StRelease} state_e;

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         cur_dev_q, cur_dev_d;
  logic [N_DEV-1:0]   grant_q, grant_d;
  logic               rd_wr_q, rd_wr_d;
  logic [ADD_LEN-1:0] num_words_q, num_words_d;
  logic [ADD_LEN:0]   start_addr_q, start_addr_d;

  logic [N_DEV-1:0]    eligible;
  logic                sel_found;
  logic [2:0]          sel_idx;
  logic                in_busy;
  logic                ack_sel;
  logic [DATA_LEN-1:0] data_sel;

  assign eligible = bus.dev_rqst & bus.dev_enable;
  assign in_busy  = (state_q == StBusy);

  // First eligible device at or above ptr, else wrap to the lowest eligible one
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < int'(N_DEV); i++) begin
      if (!sel_found && eligible[i] && (3'(i) >= ptr_q)) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
    for (int i = 0; i < int'(N_DEV); i++) begin
      if (!sel_found && eligible[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
  end

  // Next-state logic; descriptor is captured only at the selection edge
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cur_dev_d    = cur_dev_q;
    grant_d      = grant_q;
    rd_wr_d      = rd_wr_q;
    num_words_d  = num_words_q;
    start_addr_d = start_addr_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d   = StGrant;
          cur_dev_d = sel_idx;
          grant_d   = '0;
          for (int i = 0; i < int'(N_DEV); i++) begin
            if (3'(i) == sel_idx) begin
              grant_d[i]   = 1'b1;
              rd_wr_d      = bus.dev_rd_wr[i];
              num_words_d  = bus.dev_num_words[i*ADD_LEN +: ADD_LEN];
              start_addr_d = bus.dev_start_addr[i*(ADD_LEN+1) +: ADD_LEN+1];
            end
          end
        end
      end
      StGrant: state_d = StBusy;
      StBusy: begin
        if (bus.ctrl_end_flag) state_d = StRelease;
      end
      StRelease: begin
        state_d = StIdle;
        grant_d = '0;
        ptr_d   = (cur_dev_q == 3'(N_DEV - 1)) ? 3'd0 : cur_dev_q + 3'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and descriptor registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      cur_dev_q    <= '0;
      grant_q      <= '0;
      rd_wr_q      <= 1'b0;
      num_words_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cur_dev_q    <= cur_dev_d;
      grant_q      <= grant_d;
      rd_wr_q      <= rd_wr_d;
      num_words_q  <= num_words_d;
      start_addr_q <= start_addr_d;
    end
  end

  // Pick the granted device's handshake and write data
  always_comb begin
    ack_sel  = 1'b0;
    data_sel = '0;
    for (int i = 0; i < int'(N_DEV); i++) begin
      if (3'(i) == cur_dev_q) begin
        ack_sel  = bus.dev_ack_in[i];
        data_sel = bus.dev_data_in[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  // Routing is gated by BUSY so stray controller strobes never reach a device
  assign bus.ctrl_rqst       = (state_q == StGrant);
  assign bus.busy            = (state_q != StIdle);
  assign bus.cur_dev         = cur_dev_q;
  assign bus.dev_grant       = grant_q;
  assign bus.ctrl_rd_wr      = rd_wr_q;
  assign bus.ctrl_num_words  = num_words_q;
  assign bus.ctrl_start_addr = start_addr_q;
  assign bus.ctrl_dev_ack    = in_busy & ack_sel;
  assign bus.ctrl_dev_in     = in_busy ? data_sel : '0;
  assign bus.dev_dma_ack     = {N_DEV{in_busy & bus.ctrl_dma_ack}} & grant_q;
  assign bus.dev_end         = {N_DEV{in_busy & bus.ctrl_end_flag}} & grant_q;
  assign bus.dev_data_out    = in_busy ? bus.ctrl_dev_out : '0;

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 Parameter N_DEV, 4, number of requesting devices (2..8).
REQ-002 Parameter ADD_LEN, 16, word-address width; start addresses are ADD_LEN+1 bits (logical byte address).
REQ-003 Parameter DATA_LEN, 16, data word width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 dev_rqst  in  N_DEV  per-device transfer request, level, held until grant.
REQ-007 dev_enable  in  N_DEV  per-device enable mask; 0 excludes device from arbitration.
REQ-008 dev_rd_wr  in  N_DEV  per-device direction (1 = memory read, 0 = memory write).
REQ-009 dev_num_words  in  N_DEV*ADD_LEN  packed word counts, device i at bits [i*ADD_LEN +: ADD_LEN].
REQ-010 dev_start_addr  in  N_DEV*(ADD_LEN+1)  packed logical start addresses, same packing.
REQ-011 dev_ack_in  in  N_DEV  per-device data handshake (dev_ack).
REQ-012 dev_data_in  in  N_DEV*DATA_LEN  packed per-device write data.
REQ-013 dev_grant  out  N_DEV  one-hot grant; at most one bit set.
REQ-014 dev_dma_ack  out  N_DEV  controller dma_ack routed to granted device only.
REQ-015 dev_end  out  N_DEV  one-cycle completion pulse to granted device.
REQ-016 dev_data_out  out  DATA_LEN  controller dev_out, broadcast; valid only for granted device.
REQ-017 ctrl_rqst  out  1  request to DMA controller.
REQ-018 ctrl_rd_wr, ctrl_num_words, ctrl_start_addr  out  1/ADD_LEN/ADD_LEN+1  latched transfer descriptor.
REQ-019 ctrl_dev_ack  out  1; ctrl_dev_in  out  DATA_LEN  live handshake/data of granted device.
REQ-020 ctrl_dma_ack, ctrl_end_flag  in  1; ctrl_dev_out  in  DATA_LEN  controller device-side outputs.
REQ-021 busy  out  1  high from GRANT through RELEASE; cur_dev  out  3  index of granted device.

Function
REQ-022 FSM states SHALL be IDLE, GRANT, BUSY, RELEASE.
REQ-023 IDLE: eligible = dev_rqst & dev_enable; if nonzero, select first eligible index at or after pointer ptr (wrapping mod N_DEV), register dev_grant/cur_dev, latch that device's rd_wr, num_words, start_addr into descriptor registers, go GRANT; else stay.
REQ-024 GRANT: ctrl_rqst=1 for exactly this one cycle; unconditionally go BUSY.
REQ-025 BUSY: ctrl_rqst=0; route ctrl_dev_ack/ctrl_dev_in from cur_dev, ctrl_dma_ack to dev_dma_ack[cur_dev]; on ctrl_end_flag=1 go RELEASE, pulse dev_end[cur_dev] combinationally in that cycle.
REQ-026 RELEASE: one cycle; clear dev_grant; ptr <= (cur_dev+1) mod N_DEV; go IDLE.
REQ-027 Grant-to-ctrl_rqst latency SHALL be 1 cycle after selection edge; minimum spacing between two grants SHALL be 4 cycles.
REQ-028 Descriptor outputs SHALL stay constant from GRANT until leaving RELEASE regardless of device inputs.
REQ-029 Non-granted devices SHALL see dev_dma_ack=0, dev_end=0; ctrl_dev_ack=0 outside BUSY.
REQ-030 ctrl_end_flag outside BUSY SHALL be ignored.
REQ-031 dev_rqst or dev_enable of granted device falling during BUSY SHALL NOT abort the transfer.
REQ-032 Device rqst dropped while in IDLE before selection edge SHALL NOT be granted.
REQ-033 num_words=0 SHALL be forwarded unchanged (controller ends immediately); arbiter still completes RELEASE.
REQ-034 Pointer arithmetic SHALL wrap N_DEV-1 -> 0; no device starves when all request continuously.

Reset
REQ-035 reset low SHALL asynchronously force IDLE, ptr=0, cur_dev=0, dev_grant=0, descriptor registers=0; all outputs 0 while low.
REQ-036 reset asserted mid-BUSY SHALL drop grant immediately; no dev_end pulse issued.
REQ-037 First arbitration after reset release SHALL favour device 0.

Verification
REQ-038 Single: dev1 rqst, rd_wr=1, num_words=4, start_addr=0x0200 -> grant[1] next edge, ctrl_rqst one cycle, ctrl_start_addr=0x0200, dev_end[1] on ctrl_end_flag.
REQ-039 Round-robin: devices 0..3 request continuously -> grant order 0,1,2,3,0, each after RELEASE.
REQ-040 Mask: dev_enable=4'b1101, devices 1 and 2 request -> only device 2 granted; device 1 never.
REQ-041 Stability: change dev_start_addr[2] to 0xFFFF during BUSY of device 2 -> ctrl_start_addr unchanged.
REQ-042 Reset mid-transfer: reset low in BUSY -> all outputs 0 same cycle; next grant after release goes to lowest requester from 0.
REQ-043 Routing: during BUSY of device 3, toggle dev_ack_in[0] -> ctrl_dev_ack unaffected; ctrl_dma_ack appears only on dev_dma_ack[3].
